// File: rtl/clk_divider_bank.sv
// clk_divider_bank: four independent programmable square-wave dividers on
// one board clock, each with a one-cycle tick on its rising output edge.
//
// Ports:
//   clk                 board clock, the only clock
//   reset_n             synchronous active-low reset
//   enable              1 = count, 0 = freeze counters/outputs, ticks low
//   restart             synchronous clear of all channels (phase alignment)
//   clk_out0..clk_out3  registered square waves, half-period HALF0..HALF3
//   tick0..tick3        one-cycle pulse in the first cycle clk_out_i is 1

module clk_div_channel #(
   parameter int CNT_W = 26,
   parameter int HALF  = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic enable,
   input  logic restart,
   output logic clk_out,
   output logic tick
);

   // Legal range is 1 .. 2^CNT_W-1 so the terminal count fits the counter.
   if (HALF < 1 ||
       longint'(HALF) > ((longint'(1) <<< CNT_W) - longint'(1))) begin : g_bad_half
      $error("clk_div_channel: HALF=%0d out of range for CNT_W=%0d",
             HALF, CNT_W);
   end

   localparam logic [CNT_W-1:0] TERM = CNT_W'(HALF - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!reset_n || restart) begin
         cnt     <= '0;
         clk_out <= 1'b0;
         tick    <= 1'b0;
      end else if (!enable) begin
         // Hold phase; a tick due on this edge is deferred, not lost.
         tick    <= 1'b0;
      end else if (cnt == TERM) begin
         cnt     <= '0;
         clk_out <= ~clk_out;
         tick    <= ~clk_out;
      end else begin
         cnt     <= cnt + CNT_W'(1);
         tick    <= 1'b0;
      end
   end

endmodule

module clk_divider_bank #(
   parameter int CNT_W = 26,
   parameter int HALF0 = 25_000_000,
   parameter int HALF1 = 12_500_000,
   parameter int HALF2 = 6_250_000,
   parameter int HALF3 = 3_125_000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic enable,
   input  logic restart,
   output logic clk_out0,
   output logic clk_out1,
   output logic clk_out2,
   output logic clk_out3,
   output logic tick0,
   output logic tick1,
   output logic tick2,
   output logic tick3
);

   clk_div_channel #(.CNT_W(CNT_W), .HALF(HALF0)) u_ch0 (
      .clk     (clk),
      .reset_n (reset_n),
      .enable  (enable),
      .restart (restart),
      .clk_out (clk_out0),
      .tick    (tick0)
   );

   clk_div_channel #(.CNT_W(CNT_W), .HALF(HALF1)) u_ch1 (
      .clk     (clk),
      .reset_n (reset_n),
      .enable  (enable),
      .restart (restart),
      .clk_out (clk_out1),
      .tick    (tick1)
   );

   clk_div_channel #(.CNT_W(CNT_W), .HALF(HALF2)) u_ch2 (
      .clk     (clk),
      .reset_n (reset_n),
      .enable  (enable),
      .restart (restart),
      .clk_out (clk_out2),
      .tick    (tick2)
   );

   clk_div_channel #(.CNT_W(CNT_W), .HALF(HALF3)) u_ch3 (
      .clk     (clk),
      .reset_n (reset_n),
      .enable  (enable),
      .restart (restart),
      .clk_out (clk_out3),
      .tick    (tick3)
   );

endmodule

// File: tb/tb_clk_divider_bank.sv
// tb_clk_divider_bank: directed stimulus with a queue scoreboard for the
// four-channel divider bank, HALF = 2,3,4,5.

module tb_clk_divider_bank;

   typedef struct packed {
      logic [3:0] o;
      logic [3:0] t;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n;
   logic enable;
   logic restart;
   logic clk_out0, clk_out1, clk_out2, clk_out3;
   logic tick0, tick1, tick2, tick3;

   int   half [4] = '{2, 3, 4, 5};
   int   e;
   int   edge_no;
   int   errors = 0;
   int   checks = 0;
   exp_t sb [$];
   logic [3:0] prev_o;

   always #5 clk = ~clk;

   clk_divider_bank #(
      .CNT_W (8),
      .HALF0 (2),
      .HALF1 (3),
      .HALF2 (4),
      .HALF3 (5)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .enable   (enable),
      .restart  (restart),
      .clk_out0 (clk_out0),
      .clk_out1 (clk_out1),
      .clk_out2 (clk_out2),
      .clk_out3 (clk_out3),
      .tick0    (tick0),
      .tick1    (tick1),
      .tick2    (tick2),
      .tick3    (tick3)
   );

   function automatic logic [3:0] obs_o();
      return {clk_out3, clk_out2, clk_out1, clk_out0};
   endfunction

   function automatic logic [3:0] obs_t();
      return {tick3, tick2, tick1, tick0};
   endfunction

   // One clock edge: drive inputs, predict from the enabled-edge count,
   // queue the prediction, then pop and compare just after the edge.
   task automatic step(input logic rn, input logic rs, input logic en);
      exp_t x;
      exp_t got;
      logic en_edge;
      @(negedge clk);
      reset_n = rn;
      restart = rs;
      enable  = en;
      prev_o  = obs_o();
      @(posedge clk);
      edge_no++;
      en_edge = 1'b0;
      if (!rn || rs) begin
         e = 0;
      end else if (en) begin
         e++;
         en_edge = 1'b1;
      end
      for (int i = 0; i < 4; i++) begin
         x.o[i] = ((e / half[i]) % 2) == 1;
         x.t[i] = en_edge && (e % half[i] == 0) &&
                  ((e / half[i]) % 2 == 1);
      end
      sb.push_back(x);
      #1;
      got = sb.pop_front();
      checks++;
      assert (obs_o() === got.o) else begin
         errors++;
         $error("FAIL clk_out edge=%0d e=%0d got=%b exp=%b",
                edge_no, e, obs_o(), got.o);
      end
      checks++;
      assert (obs_t() === got.t) else begin
         errors++;
         $error("FAIL tick edge=%0d e=%0d got=%b exp=%b",
                edge_no, e, obs_t(), got.t);
      end
   endtask

   initial begin
      e       = 0;
      edge_no = 0;
      reset_n = 1'b0;
      restart = 1'b0;
      enable  = 1'b1;
      prev_o  = '0;

      // 1: reset held with enable=1
      repeat (3) step(1'b0, 1'b0, 1'b1);
      checks++;
      assert ({obs_o(), obs_t()} === 8'h00) else begin
         errors++;
         $error("FAIL reset_state got=%b exp=%b",
                {obs_o(), obs_t()}, 8'h00);
      end

      // 2: 20 enabled edges
      for (int n = 1; n <= 20; n++) begin
         step(1'b1, 1'b0, 1'b1);
         if (n == 2 || n == 6 || n == 10) begin
            checks++;
            assert (clk_out0 === 1'b1 && tick0 === 1'b1) else begin
               errors++;
               $error("FAIL ch0_rise n=%0d got=%b%b exp=11",
                      n, clk_out0, tick0);
            end
         end
         if (n == 10) begin
            checks++;
            assert (clk_out3 === 1'b0 && prev_o[3] === 1'b1) else begin
               errors++;
               $error("FAIL ch3_fall n=%0d got=%b exp=0", n, clk_out3);
            end
         end
      end

      // 3: restart, run to 3, freeze 4 edges, re-enable
      step(1'b1, 1'b1, 1'b1);
      repeat (3) step(1'b1, 1'b0, 1'b1);
      repeat (4) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1);
      checks++;
      assert (prev_o[0] === 1'b1 && clk_out0 === 1'b0) else begin
         errors++;
         $error("FAIL freeze_fall got=%b exp=0 prev=%b",
                clk_out0, prev_o[0]);
      end

      // 4: reach enabled edge 7, restart with enable=0
      repeat (3) step(1'b1, 1'b0, 1'b1);
      checks++;
      assert (clk_out2 === 1'b1) else begin
         errors++;
         $error("FAIL ch2_mid got=%b exp=1", clk_out2);
      end
      step(1'b1, 1'b1, 1'b0);
      checks++;
      assert (obs_o() === 4'b0000) else begin
         errors++;
         $error("FAIL restart_clear got=%b exp=0000", obs_o());
      end

      // 5: to e=6 (clk_out3=1, tick0=1), then one reset edge
      repeat (6) step(1'b1, 1'b0, 1'b1);
      checks++;
      assert (clk_out3 === 1'b1 && tick0 === 1'b1) else begin
         errors++;
         $error("FAIL pre_reset got=%b%b exp=11", clk_out3, tick0);
      end
      step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      checks++;
      assert (obs_t() === 4'b0000) else begin
         errors++;
         $error("FAIL post_reset_tick got=%b exp=0000", obs_t());
      end

      // 6: restart, 32 enabled edges, ch2 falls align with ch0 falls
      step(1'b1, 1'b1, 1'b1);
      for (int n = 1; n <= 32; n++) begin
         step(1'b1, 1'b0, 1'b1);
         if (n % 8 == 0) begin
            checks++;
            assert (prev_o[2] === 1'b1 && clk_out2 === 1'b0 &&
                    prev_o[0] === 1'b1 && clk_out0 === 1'b0) else begin
               errors++;
               $error("FAIL align n=%0d got=%b exp=ch0,ch2 falling",
                      n, obs_o());
            end
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
